// File: rtl/mem_bank_pkg.sv
// rtl/mem_bank_pkg.sv - shared widths, lane slicing and select-stage type for the banked ECC memory
package mem_bank_pkg;

    // Widest bank index carried in a select stage (up to 16 banks)
    localparam int SEL_MAX_W = 4;

    function automatic int parity_bits(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

    function automatic int encoded_word(input int data_width);
        return data_width + parity_bits(data_width);
    endfunction

    function automatic int lane_lo(input int lane, input int lane_width);
        return lane * lane_width;
    endfunction

    typedef struct packed {
        logic                 vld;
        logic [SEL_MAX_W-1:0] sel;
    } sel_stage_t;

endpackage

// File: rtl/rd_sel_pipe.sv
// rtl/rd_sel_pipe.sv - DEPTH-stage {vld, sel} shift register with flush and async reset
module rd_sel_pipe
    import mem_bank_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  sel_stage_t in_stage,
    output sel_stage_t out_stage,
    output logic       busy
);

    sel_stage_t stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < DEPTH; n++) begin
                stages[n] <= '0;
            end
        end else begin
            stages[0].vld <= in_stage.vld & ~flush;
            stages[0].sel <= in_stage.sel;
            for (int n = 1; n < DEPTH; n++) begin
                stages[n].vld <= stages[n-1].vld & ~flush;
                stages[n].sel <= stages[n-1].sel;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int n = 0; n < DEPTH; n++) begin
            busy = busy | stages[n].vld;
        end
    end

    assign out_stage = stages[DEPTH-1];

endmodule

// File: rtl/bank_rd_return_mux.sv
// rtl/bank_rd_return_mux.sv - pipelined bank select tracking and read-return lane mux with held output
module bank_rd_return_mux
    import mem_bank_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_BITS  = parity_bits(DATA_WIDTH),
    parameter int ENCODED_WORD = DATA_WIDTH + PARITY_BITS,
    parameter int NUM_BANKS    = 4,
    parameter int BANK_SEL_W   = $clog2(NUM_BANKS),
    parameter int READ_LATENCY = 2,
    parameter int OUT_REG      = 1
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic                                  i_rd_en,
    input  logic [BANK_SEL_W-1:0]                 i_bank_sel,
    input  logic                                  i_flush,
    input  logic [NUM_BANKS*(ENCODED_WORD+1)-1:0] i_bank_data,
    output logic [ENCODED_WORD:0]                 o_rd_data,
    output logic                                  o_rd_valid,
    output logic [BANK_SEL_W-1:0]                 o_rd_bank,
    output logic                                  o_busy,
    output logic                                  o_sel_err
);

    localparam int LANE_W = ENCODED_WORD + 1;

    logic                  sel_legal;
    sel_stage_t            in_stage;
    sel_stage_t            last_stage;
    logic [LANE_W-1:0]     mux_data;
    logic [LANE_W-1:0]     hold_data;
    logic [BANK_SEL_W-1:0] hold_bank;

    // Widened compare so non-power-of-two bank counts can flag indices past the last bank
    assign sel_legal    = ({1'b0, i_bank_sel} < (BANK_SEL_W+1)'(NUM_BANKS));
    assign in_stage.vld = i_rd_en & sel_legal;
    assign in_stage.sel = SEL_MAX_W'(i_bank_sel);

    rd_sel_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_sel_pipe (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_flush),
        .in_stage  (in_stage),
        .out_stage (last_stage),
        .busy      (o_busy)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sel_err <= 1'b0;
        end else begin
            o_sel_err <= i_rd_en & ~sel_legal;
        end
    end

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (last_stage.sel == SEL_MAX_W'(k)) begin
                mux_data = i_bank_data[lane_lo(k, LANE_W) +: LANE_W];
            end
        end
    end

    // Doubles as the output register (OUT_REG=1) or the hold register (OUT_REG=0)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_data <= '0;
            hold_bank <= '0;
        end else if (last_stage.vld) begin
            hold_data <= mux_data;
            hold_bank <= last_stage.sel[BANK_SEL_W-1:0];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic vld_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= last_stage.vld;
                end
            end

            assign o_rd_data  = hold_data;
            assign o_rd_bank  = hold_bank;
            assign o_rd_valid = vld_q;
        end else begin : g_out_comb
            assign o_rd_data  = last_stage.vld ? mux_data : hold_data;
            assign o_rd_bank  = last_stage.vld ? last_stage.sel[BANK_SEL_W-1:0] : hold_bank;
            assign o_rd_valid = last_stage.vld;
        end
    endgenerate

endmodule

// File: tb/tb_bank_rd_return_mux.sv
// tb/tb_bank_rd_return_mux.sv - scoreboard bench for bank_rd_return_mux in three configurations
module tb_bank_rd_return_mux;

    logic clk;
    logic rst_n;

    // default configuration: 4 banks, latency 2, registered output
    logic        rd_en, flush;
    logic [1:0]  bank_sel;
    logic [51:0] bank_data;
    logic [12:0] rd_data;
    logic        rd_valid, busy, sel_err;
    logic [1:0]  rd_bank;

    // 3 banks
    logic        rd_en3, flush3;
    logic [1:0]  bank_sel3;
    logic [38:0] bank_data3;
    logic [12:0] rd_data3;
    logic        rd_valid3, busy3, sel_err3;
    logic [1:0]  rd_bank3;

    // combinational output, latency 1
    logic        rd_en0, flush0;
    logic [1:0]  bank_sel0;
    logic [51:0] bank_data0;
    logic [12:0] rd_data0;
    logic        rd_valid0, busy0, sel_err0;
    logic [1:0]  rd_bank0;

    int checks   = 0;
    int failures = 0;

    logic [14:0] exp_q[$];
    logic [14:0] exp0_q[$];

    bank_rd_return_mux u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en), .i_bank_sel(bank_sel),
        .i_flush(flush), .i_bank_data(bank_data), .o_rd_data(rd_data),
        .o_rd_valid(rd_valid), .o_rd_bank(rd_bank), .o_busy(busy), .o_sel_err(sel_err)
    );

    bank_rd_return_mux #(.NUM_BANKS(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en3), .i_bank_sel(bank_sel3),
        .i_flush(flush3), .i_bank_data(bank_data3), .o_rd_data(rd_data3),
        .o_rd_valid(rd_valid3), .o_rd_bank(rd_bank3), .o_busy(busy3), .o_sel_err(sel_err3)
    );

    bank_rd_return_mux #(.READ_LATENCY(1), .OUT_REG(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en0), .i_bank_sel(bank_sel0),
        .i_flush(flush0), .i_bank_data(bank_data0), .o_rd_data(rd_data0),
        .o_rd_valid(rd_valid0), .o_rd_bank(rd_bank0), .o_busy(busy0), .o_sel_err(sel_err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL main_unexpected_return actual=%0h/%0d expected=none", rd_data, rd_bank);
            end else begin
                logic [14:0] e;
                e = exp_q.pop_front();
                if ({rd_bank, rd_data} !== e) begin
                    failures++;
                    $display("FAIL main_return actual=%0h/%0d expected=%0h/%0d",
                             rd_data, rd_bank, e[12:0], e[14:13]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rd_valid0) begin
            checks++;
            if (exp0_q.size() == 0) begin
                failures++;
                $display("FAIL comb_unexpected_return actual=%0h/%0d expected=none", rd_data0, rd_bank0);
            end else begin
                logic [14:0] e;
                e = exp0_q.pop_front();
                if ({rd_bank0, rd_data0} !== e) begin
                    failures++;
                    $display("FAIL comb_return actual=%0h/%0d expected=%0h/%0d",
                             rd_data0, rd_bank0, e[12:0], e[14:13]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        {rd_en, flush, bank_sel, bank_data}     = '0;
        {rd_en3, flush3, bank_sel3, bank_data3} = '0;
        {rd_en0, flush0, bank_sel0, bank_data0} = '0;
        #12;
        chk("reset_data",    32'(rd_data),  0);
        chk("reset_valid",   32'(rd_valid), 0);
        chk("reset_bank",    32'(rd_bank),  0);
        chk("reset_busy",    32'(busy),     0);
        chk("reset_sel_err", 32'(sel_err),  0);
        rst_n = 1'b1;

        // single read from bank 2
        bank_data[26 +: 13] = 13'h0A5C;
        step();
        rd_en = 1'b1; bank_sel = 2'd2; exp_q.push_back({2'd2, 13'h0A5C});
        step();
        rd_en = 1'b0;
        step();
        step();
        step();
        bank_data[26 +: 13] = 13'h1111;
        chk("single_valid_after", 32'(rd_valid), 0);
        chk("single_hold_data",   32'(rd_data),  32'h0A5C);
        chk("single_hold_bank",   32'(rd_bank),  2);
        step();
        chk("single_hold_data2",  32'(rd_data),  32'h0A5C);

        // back-to-back to all four banks
        for (int k = 0; k < 4; k++) bank_data[k*13 +: 13] = 13'h0100 + 13'(k);
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("b2b_busy_c%0d", c), 32'(busy), (c >= 1 && c <= 5) ? 1 : 0);
            if (c < 4) begin
                rd_en = 1'b1; bank_sel = 2'(c);
                exp_q.push_back({2'(c), 13'h0100 + 13'(c)});
            end else begin
                rd_en = 1'b0;
            end
        end

        // flush mid-flight: nothing may return
        step();
        rd_en = 1'b1; bank_sel = 2'd1;
        step();
        chk("flush_busy_c1", 32'(busy), 1);
        bank_sel = 2'd3; flush = 1'b1;
        step();
        rd_en = 1'b0; flush = 1'b0;
        chk("flush_busy_c2", 32'(busy), 0);
        for (int c = 3; c < 7; c++) begin
            step();
            chk($sformatf("flush_valid_c%0d", c), 32'(rd_valid), 0);
        end
        chk("flush_hold_data", 32'(rd_data), 32'h0103);

        // asynchronous reset mid-cycle drops the request
        step();
        rd_en = 1'b1; bank_sel = 2'd0;
        step();
        rd_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data",  32'(rd_data),  0);
        chk("arst_bank",  32'(rd_bank),  0);
        chk("arst_valid", 32'(rd_valid), 0);
        chk("arst_busy",  32'(busy),     0);
        #2 rst_n = 1'b1;
        for (int c = 2; c < 7; c++) begin
            step();
            chk($sformatf("arst_valid_c%0d", c), 32'(rd_valid), 0);
        end

        // 3 banks: illegal index then a legal read
        step();
        rd_en3 = 1'b1; bank_sel3 = 2'd3;
        step();
        rd_en3 = 1'b0;
        chk("selerr_pulse", 32'(sel_err3), 1);
        chk("selerr_busy",  32'(busy3),    0);
        step();
        chk("selerr_clear", 32'(sel_err3), 0);
        step();
        chk("selerr_no_valid_a", 32'(rd_valid3), 0);
        step();
        chk("selerr_no_valid_b", 32'(rd_valid3), 0);
        bank_data3[26 +: 13] = 13'h0777;
        rd_en3 = 1'b1; bank_sel3 = 2'd2;
        step();
        rd_en3 = 1'b0;
        chk("nb3_legal_no_err", 32'(sel_err3), 0);
        step();
        step();
        chk("nb3_valid", 32'(rd_valid3), 1);
        chk("nb3_data",  32'(rd_data3),  32'h0777);
        chk("nb3_bank",  32'(rd_bank3),  2);

        // combinational output, latency 1
        bank_data0[0 +: 13] = 13'h1FFF;
        step();
        rd_en0 = 1'b1; bank_sel0 = 2'd0; exp0_q.push_back({2'd0, 13'h1FFF});
        step();
        rd_en0 = 1'b0;
        chk("comb_valid_c1", 32'(rd_valid0), 1);
        chk("comb_data_c1",  32'(rd_data0),  32'h1FFF);
        step();
        bank_data0[0 +: 13] = 13'h0123;
        #1;
        chk("comb_valid_c2", 32'(rd_valid0), 0);
        chk("comb_hold_c2",  32'(rd_data0),  32'h1FFF);

        step();
        step();
        chk("main_queue_drained", 32'(exp_q.size()),  0);
        chk("comb_queue_drained", 32'(exp0_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
